// File: rtl/cmd_pkg.sv
// Shared types and helpers for the serial command dispatcher: opcodes, FSM states,
// default frame geometry and address-width functions.
package cmd_pkg;

    localparam logic [7:0] OP_READROW = 8'h52;
    localparam logic [7:0] OP_PIXEL   = 8'h50;
    localparam logic [7:0] OP_FILL    = 8'h46;
    localparam logic [7:0] OP_BRIGHT  = 8'h42;

    localparam int ERR_COUNT_W = 8;

    localparam int DEF_PIXEL_HEIGHT    = 32;
    localparam int DEF_PIXEL_WIDTH     = 64;
    localparam int DEF_BYTES_PER_PIXEL = 3;

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} dispatch_state_t;

    function automatic int num_row_address_bits(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    function automatic int num_column_address_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int num_pixelcolorselect_bits(input int bpp);
        return (bpp > 1) ? $clog2(bpp) : 1;
    endfunction

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Inactivity counter: cleared on demand, counts while enabled, flags the cycle in
// which the count would reach TIMEOUT_CYCLES.
module cmd_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Expiry coincides with the increment that reaches TIMEOUT_CYCLES.
    assign expire = enable && !clear && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/control_cmd_dispatcher.sv
// Opcode decoder and byte router for the serial command path; also muxes the
// handlers' framebuffer write ports onto the single RAM port.
module control_cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int NUM_HANDLERS = 4,
    parameter logic [NUM_HANDLERS*8-1:0] OPCODE_TABLE = {OP_BRIGHT, OP_FILL, OP_PIXEL, OP_READROW},
    parameter int PIXEL_HEIGHT    = DEF_PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int TIMEOUT_CYCLES  = 65535,
    localparam int RW = num_row_address_bits(PIXEL_HEIGHT),
    localparam int CW = num_column_address_bits(PIXEL_WIDTH),
    localparam int PW = num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data_valid,
    input  logic [7:0]                 data_in,
    output logic [NUM_HANDLERS-1:0]    handler_enable,
    output logic [7:0]                 handler_data,
    output logic [NUM_HANDLERS-1:0]    handler_abort,
    input  logic [NUM_HANDLERS-1:0]    handler_done,
    input  logic [NUM_HANDLERS-1:0]    handler_we,
    input  logic [NUM_HANDLERS-1:0]    handler_as,
    input  logic [NUM_HANDLERS*RW-1:0] handler_row,
    input  logic [NUM_HANDLERS*CW-1:0] handler_col,
    input  logic [NUM_HANDLERS*PW-1:0] handler_pix,
    input  logic [NUM_HANDLERS*8-1:0]  handler_do,
    output logic                       ram_we,
    output logic                       ram_access_start,
    output logic [RW-1:0]              ram_row,
    output logic [CW-1:0]              ram_col,
    output logic [PW-1:0]              ram_pix,
    output logic [7:0]                 ram_do,
    output logic                       busy,
    output logic                       unknown_opcode,
    output logic                       timeout,
    output logic [ERR_COUNT_W-1:0]     err_count
);

    localparam int IW = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;

    dispatch_state_t state;
    logic [IW-1:0]   active_idx;
    logic            prev_as;

    logic            match;
    logic [IW-1:0]   match_idx;
    logic            wd_clear, wd_enable, wd_expire;

    logic            sel_done, sel_we, sel_as;
    logic [RW-1:0]   sel_row;
    logic [CW-1:0]   sel_col;
    logic [PW-1:0]   sel_pix;
    logic [7:0]      sel_do;

    // Scan downward so the lowest matching slot is the one kept.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_HANDLERS - 1; i >= 0; i--) begin
            if (data_in == OPCODE_TABLE[i*8 +: 8]) begin
                match     = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    assign sel_done = handler_done[active_idx];
    assign sel_we   = handler_we[active_idx];
    assign sel_as   = handler_as[active_idx];
    assign sel_row  = handler_row[int'(active_idx)*RW +: RW];
    assign sel_col  = handler_col[int'(active_idx)*CW +: CW];
    assign sel_pix  = handler_pix[int'(active_idx)*PW +: PW];
    assign sel_do   = handler_do[int'(active_idx)*8 +: 8];

    assign handler_data   = data_in;
    assign handler_enable = (state == ACTIVE && data_valid) ? (NUM_HANDLERS'(1) << active_idx) : '0;
    assign busy           = (state != IDLE);

    assign wd_enable = (state == ACTIVE);
    assign wd_clear  = data_valid && ((state == ACTIVE) || (state == IDLE && match));

    cmd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            active_idx       <= '0;
            prev_as          <= 1'b0;
            unknown_opcode   <= 1'b0;
            timeout          <= 1'b0;
            handler_abort    <= '0;
            err_count        <= '0;
            ram_we           <= 1'b0;
            ram_access_start <= 1'b0;
            ram_row          <= '0;
            ram_col          <= '0;
            ram_pix          <= '0;
            ram_do           <= '0;
        end else begin
            unknown_opcode <= 1'b0;
            timeout        <= 1'b0;
            handler_abort  <= '0;
            ram_we         <= 1'b0;
            ram_do         <= '0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        if (match) begin
                            state      <= ACTIVE;
                            active_idx <= match_idx;
                            // Adopt the new handler's level so a switch is never seen as a toggle.
                            prev_as    <= handler_as[match_idx];
                        end else begin
                            unknown_opcode <= 1'b1;
                            err_count      <= sat_inc(err_count);
                        end
                    end
                end
                ACTIVE: begin
                    ram_we  <= sel_we;
                    ram_row <= sel_row;
                    ram_col <= sel_col;
                    ram_pix <= sel_pix;
                    ram_do  <= sel_do;
                    prev_as <= sel_as;
                    if (sel_as != prev_as)
                        ram_access_start <= ~ram_access_start;
                    if (sel_done) begin
                        state <= IDLE;
                    end else if (wd_expire) begin
                        state         <= ABORT;
                        handler_abort <= NUM_HANDLERS'(1) << active_idx;
                        timeout       <= 1'b1;
                        err_count     <= sat_inc(err_count);
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_cmd_dispatcher.sv
// Self-checking bench: opcode decode table, payload forwarding and RAM-mux scoreboards,
// watchdog abort, handler switching, async reset and error-count saturation.
module tb_control_cmd_dispatcher;
    import cmd_pkg::*;

    localparam int NH = 4;
    localparam int TO = 16;
    localparam int RW = num_row_address_bits(DEF_PIXEL_HEIGHT);
    localparam int CW = num_column_address_bits(DEF_PIXEL_WIDTH);
    localparam int PW = num_pixelcolorselect_bits(DEF_BYTES_PER_PIXEL);

    logic clk, reset, data_valid;
    logic [7:0] data_in, handler_data, ram_do;
    logic [NH-1:0] handler_enable, handler_abort, handler_done, handler_we, handler_as;
    logic [NH*RW-1:0] handler_row;
    logic [NH*CW-1:0] handler_col;
    logic [NH*PW-1:0] handler_pix;
    logic [NH*8-1:0]  handler_do;
    logic ram_we, ram_access_start, busy, unknown_opcode, timeout;
    logic [RW-1:0] ram_row;
    logic [CW-1:0] ram_col;
    logic [PW-1:0] ram_pix;
    logic [7:0] err_count;

    control_cmd_dispatcher #(.NUM_HANDLERS(NH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in),
        .handler_enable(handler_enable), .handler_data(handler_data), .handler_abort(handler_abort),
        .handler_done(handler_done), .handler_we(handler_we), .handler_as(handler_as),
        .handler_row(handler_row), .handler_col(handler_col), .handler_pix(handler_pix),
        .handler_do(handler_do), .ram_we(ram_we), .ram_access_start(ram_access_start),
        .ram_row(ram_row), .ram_col(ram_col), .ram_pix(ram_pix), .ram_do(ram_do),
        .busy(busy), .unknown_opcode(unknown_opcode), .timeout(timeout), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [NH-1:0] en; logic [7:0] d; } fwd_t;
    typedef struct packed { logic [RW-1:0] row; logic [CW-1:0] col; logic [PW-1:0] pix; logic [7:0] d; } wr_t;
    typedef struct { logic [7:0] op; int slot; logic [7:0] err; } vec_t;

    fwd_t fwd_q[$];
    wr_t  wr_q[$];
    vec_t tbl[8];
    int   vectors, miscompares, toggles, tog0;
    logic last_as;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: combinational forwarding checked mid-cycle, registered RAM port after the edge.
    task automatic tick();
        fwd_t f;
        wr_t  w;
        @(negedge clk);
        if (fwd_q.size() != 0) begin
            f = fwd_q.pop_front();
            chk("handler_enable", handler_enable, f.en);
            chk("handler_data", handler_data, f.d);
        end else begin
            chk("handler_enable_idle", handler_enable, 0);
        end
        @(posedge clk);
        #1;
        if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk("ram_we", ram_we, 1);
            chk("ram_row", ram_row, w.row);
            chk("ram_col", ram_col, w.col);
            chk("ram_pix", ram_pix, w.pix);
            chk("ram_do", ram_do, w.d);
        end else begin
            chk("ram_we_idle", ram_we, 0);
        end
        if (ram_access_start !== last_as) toggles++;
        last_as      = ram_access_start;
        data_valid   = 1'b0;
        handler_done = '0;
        handler_we   = '0;
    endtask

    task automatic send(input logic [7:0] b, input int slot);
        fwd_t f;
        data_valid = 1'b1;
        data_in    = b;
        if (slot >= 0) begin
            f.en = NH'(1) << slot;
            f.d  = b;
            fwd_q.push_back(f);
        end
        tick();
    endtask

    // Stub handler write: raise we, toggle its access level, present address/data.
    task automatic hw(input int s, input int r, input int c, input int p, input logic [7:0] d, input bit pass);
        wr_t w;
        handler_we[s] = 1'b1;
        handler_as[s] = ~handler_as[s];
        handler_row[s*RW +: RW] = RW'(r);
        handler_col[s*CW +: CW] = CW'(c);
        handler_pix[s*PW +: PW] = PW'(p);
        handler_do[s*8 +: 8]    = d;
        if (pass) begin
            w.row = RW'(r); w.col = CW'(c); w.pix = PW'(p); w.d = d;
            wr_q.push_back(w);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; toggles = 0; last_as = 1'b0;
        reset = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        handler_done = '0; handler_we = '0; handler_as = '0;
        handler_row = '0; handler_col = '0; handler_pix = '0; handler_do = '0;

        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err_count, 0);
        chk("rst_abort", handler_abort, 0);
        chk("rst_flags", {unknown_opcode, timeout, ram_access_start}, 0);
        chk("rst_ram", {ram_row, ram_col, ram_pix, ram_do}, 0);
        reset = 1'b1;
        tick();

        tbl[0] = '{8'h52,  0, 8'd0};
        tbl[1] = '{8'h7E, -1, 8'd1};
        tbl[2] = '{8'h50,  1, 8'd1};
        tbl[3] = '{8'h46,  2, 8'd1};
        tbl[4] = '{8'h42,  3, 8'd1};
        tbl[5] = '{8'h00, -1, 8'd2};
        tbl[6] = '{8'hFF, -1, 8'd3};
        tbl[7] = '{8'h53, -1, 8'd4};
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].op, -1);
            chk("op_busy", busy, tbl[i].slot >= 0);
            chk("op_unknown", unknown_opcode, tbl[i].slot < 0);
            chk("op_err_count", err_count, tbl[i].err);
            if (tbl[i].slot >= 0) begin
                send(8'(8'hA0 + i), tbl[i].slot);
                handler_done[tbl[i].slot] = 1'b1;
                tick();
                chk("op_done_busy", busy, 0);
            end else begin
                tick();
                chk("unknown_one_cycle", unknown_opcode, 0);
            end
        end

        // Readrow: opcode, row byte, four written payload bytes; last byte arrives with done.
        tog0 = toggles;
        send(8'h52, -1);
        send(8'h03, 0);
        for (int k = 0; k < 4; k++) begin
            hw(0, 3, k, k % 3, 8'(8'h10 + k), 1);
            if (k == 3) handler_done[0] = 1'b1;
            send(8'(8'h10 + k), 0);
        end
        chk("readrow_busy_after_done", busy, 0);
        chk("readrow_toggles", toggles, tog0 + 4);

        // Unknown opcode, then accepted opcode; done from another slot ignored.
        send(8'h7E, -1);
        chk("unk_pulse", unknown_opcode, 1);
        chk("unk_err", err_count, 5);
        send(8'h52, -1);
        chk("accept_after_unk", busy, 1);
        handler_done[2] = 1'b1;
        tick();
        chk("foreign_done_ignored", busy, 1);
        send(8'h99, 0);
        handler_done[0] = 1'b1;
        tick();
        chk("done_idle", busy, 0);

        // Watchdog: a byte restarts the count; then TO silent cycles abort slot 1.
        send(8'h50, -1);
        repeat (10) tick();
        send(8'h33, 1);
        repeat (TO - 1) tick();
        chk("wd_no_early_abort", handler_abort, 0);
        chk("wd_busy_before", busy, 1);
        tick();
        chk("wd_abort", handler_abort, 4'b0010);
        chk("wd_timeout", timeout, 1);
        chk("wd_err", err_count, 6);
        send(8'h52, -1);
        chk("abort_one_cycle", {handler_abort, timeout}, 0);
        chk("abort_drops_byte", busy, 0);
        chk("abort_err_hold", err_count, 6);

        // Back-to-back readrows, then switch to fill whose access level differs.
        tog0 = toggles;
        for (int r = 0; r < 2; r++) begin
            send(8'h52, -1);
            send(8'(r), 0);
            hw(0, r, 5, 1, 8'(8'hC0 + r), 1);
            send(8'hD0, 0);
            handler_done[0] = 1'b1;
            tick();
        end
        chk("b2b_toggles", toggles, tog0 + 2);
        handler_as[2] = ~handler_as[0];
        tick();
        send(8'h46, -1);
        tick();
        tick();
        chk("switch_no_toggle", toggles, tog0 + 2);
        hw(0, 1, 1, 1, 8'h55, 0);
        hw(2, 7, 9, 2, 8'hE7, 1);
        tick();
        chk("fill_write_toggle", toggles, tog0 + 3);
        handler_done[2] = 1'b1;
        tick();
        chk("fill_done", busy, 0);
        hw(2, 4, 4, 0, 8'h44, 0);
        tick();
        chk("idle_write_blocked", toggles, tog0 + 3);

        // Async reset in the middle of a payload.
        send(8'h52, -1);
        send(8'h01, 0);
        hw(0, 2, 2, 2, 8'h77, 1);
        tick();
        reset = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ram", {ram_we, ram_access_start, ram_row, ram_col, ram_pix, ram_do}, 0);
        chk("mid_rst_abort", {handler_abort, timeout, unknown_opcode}, 0);
        chk("mid_rst_err", err_count, 0);
        last_as = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_no_abort", handler_abort, 0);
        send(8'h52, -1);
        chk("post_rst_dispatch", busy, 1);
        send(8'h02, 0);
        handler_done[0] = 1'b1;
        tick();
        chk("post_rst_done", busy, 0);

        // Error counter saturates at 255.
        repeat (256) send(8'hEE, -1);
        chk("err_saturate", err_count, 255);
        send(8'hEE, -1);
        chk("err_hold_255", err_count, 255);
        chk("err_unknown_still_pulses", unknown_opcode, 1);

        chk("fwd_queue_drained", fwd_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
